// File: rtl/router_pkg.sv
// Shared constants, state encoding and header/parity helpers for the router packet transmitter.
package router_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int BUF_DEPTH = 63;

  localparam logic [ADDR_W-1:0] PORT_0       = 2'd0;
  localparam logic [ADDR_W-1:0] PORT_1       = 2'd1;
  localparam logic [ADDR_W-1:0] PORT_2       = 2'd2;
  localparam logic [ADDR_W-1:0] PORT_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_HEADER  = 2'd1,
    TX_PAYLOAD = 2'd2,
    TX_PARITY  = 2'd3
  } tx_state_t;

  function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic [DATA_W-1:0] parity_fold(input logic [DATA_W-1:0] par,
                                                    input logic [DATA_W-1:0] data);
    return par ^ data;
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload buffer: register array with async read, write/read pointers, fill count and flush.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic [LEN_W-1:0]  count,
  output logic              full
);

  logic [DATA_W-1:0] mem_r [BUF_DEPTH];
  logic [LEN_W-1:0]  wr_ptr_r;
  logic [LEN_W-1:0]  rd_ptr_r;
  logic [LEN_W-1:0]  count_r;
  logic              wr_ok_s;

  assign full    = (count_r == LEN_W'(BUF_DEPTH));
  assign wr_ok_s = wr_en && !full;
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and count; reads replay the packet and do not shrink the count until flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= 6'd0;
      rd_ptr_r <= 6'd0;
      count_r  <= 6'd0;
    end else if (flush) begin
      wr_ptr_r <= 6'd0;
      rd_ptr_r <= 6'd0;
      count_r  <= 6'd0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 6'd1;
        count_r  <= count_r + 6'd1;
      end
      if (rd_en) begin
        rd_ptr_r <= rd_ptr_r + 6'd1;
      end
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then streams header, payload and parity
// without bubbles, holding each beat while the router is busy.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [LEN_W-1:0]  buf_count,
  output logic              buf_full,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              inject_err,
  input  logic              router_busy,
  output logic [DATA_W-1:0] data_out,
  output logic              packet_valid,
  output logic              tx_active,
  output logic              tx_done,
  output logic              start_err
);

  tx_state_t         state_r;
  logic [DATA_W-1:0] data_out_r;
  logic [DATA_W-1:0] par_r;
  logic              pv_r;
  logic              tx_done_r;
  logic              start_err_r;
  logic              inj_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  sent_r;

  logic              consume_s;
  logic              idle_s;
  logic              wr_take_s;
  logic              more_s;
  logic              rd_en_s;
  logic              flush_s;
  logic [LEN_W-1:0]  len_eff_s;
  logic [DATA_W-1:0] rd_data_s;

  assign idle_s    = (state_r == TX_IDLE);
  assign tx_active = !idle_s;
  assign consume_s = tx_active && !router_busy;
  // A write landing in the same cycle as start belongs to this packet.
  assign wr_take_s = wr_en && idle_s && !buf_full;
  assign len_eff_s = buf_count + {{(LEN_W-1){1'b0}}, wr_take_s};
  assign more_s    = (sent_r < len_r);
  assign rd_en_s   = consume_s && ((state_r == TX_HEADER) || (state_r == TX_PAYLOAD)) && more_s;
  assign flush_s   = consume_s && (state_r == TX_PARITY);

  assign data_out     = data_out_r;
  assign packet_valid = pv_r;
  assign tx_done      = tx_done_r;
  assign start_err    = start_err_r;

  router_pkt_buf u_buf (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en && idle_s),
    .wr_data (wr_data),
    .rd_en   (rd_en_s),
    .flush   (flush_s),
    .rd_data (rd_data_s),
    .count   (buf_count),
    .full    (buf_full)
  );

  // Transmit FSM with parity accumulator and registered beat outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= TX_IDLE;
      data_out_r  <= 8'h00;
      par_r       <= 8'h00;
      pv_r        <= 1'b0;
      tx_done_r   <= 1'b0;
      start_err_r <= 1'b0;
      inj_r       <= 1'b0;
      len_r       <= 6'd0;
      sent_r      <= 6'd0;
    end else begin
      tx_done_r   <= 1'b0;
      start_err_r <= 1'b0;
      case (state_r)
        TX_IDLE: begin
          if (start) begin
            if ((len_eff_s != 6'd0) && (dest_addr != PORT_ILLEGAL)) begin
              state_r    <= TX_HEADER;
              len_r      <= len_eff_s;
              inj_r      <= inject_err;
              sent_r     <= 6'd0;
              data_out_r <= make_header(len_eff_s, dest_addr);
              par_r      <= make_header(len_eff_s, dest_addr);
              pv_r       <= 1'b1;
            end else begin
              start_err_r <= 1'b1;
            end
          end
        end
        TX_HEADER, TX_PAYLOAD: begin
          if (consume_s) begin
            if (more_s) begin
              data_out_r <= rd_data_s;
              par_r      <= parity_fold(par_r, rd_data_s);
              sent_r     <= sent_r + 6'd1;
              state_r    <= TX_PAYLOAD;
            end else begin
              data_out_r <= parity_fold(par_r, {{(DATA_W-1){1'b0}}, inj_r});
              pv_r       <= 1'b0;
              state_r    <= TX_PARITY;
            end
          end
        end
        TX_PARITY: begin
          if (consume_s) begin
            data_out_r <= 8'h00;
            tx_done_r  <= 1'b1;
            state_r    <= TX_IDLE;
          end
        end
        default: begin
          state_r    <= TX_IDLE;
          data_out_r <= 8'h00;
          pv_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule
